// File: rtl/known_ch_table.sv
// Known cluster-head table: stores heard CH adverts, ages them out and reselects
// the best CH (max Q, then min hops, then lowest index) after every change.
module known_ch_table #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int AGE_WIDTH  = 8,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic                  en_KCH,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    input  logic                  age_tick,
    input  logic [AGE_WIDTH-1:0]  age_limit,
    output logic                  kch_ready,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH,
    output logic [WORD_WIDTH-1:0] chosenQ,
    output logic                  ch_valid,
    output logic [IW:0]           ch_count,
    output logic                  sel_done,
    output logic                  adv_drop,
    output logic [2:0]            dbg_state_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UPDATE = 3'd1;
    localparam logic [2:0] S_AGE    = 3'd2;
    localparam logic [2:0] S_SCAN   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    typedef logic [WORD_WIDTH-1:0] word_t;

    logic [2:0]           state_q, state_d;
    logic [DEPTH-1:0]     vld_q, vld_d;
    word_t                id_q[DEPTH], id_d[DEPTH];
    word_t                hops_q[DEPTH], hops_d[DEPTH];
    word_t                qv_q[DEPTH], qv_d[DEPTH];
    logic [AGE_WIDTH-1:0] age_q[DEPTH], age_d[DEPTH];
    word_t                adv_id_q, adv_id_d, adv_hops_q, adv_hops_d, adv_qv_q, adv_qv_d;
    logic                 pend_q, pend_d;
    logic [IW-1:0]        scan_idx_q, scan_idx_d;
    logic                 best_found_q, best_found_d;
    word_t                best_id_q, best_id_d, best_hops_q, best_hops_d, best_qv_q, best_qv_d;
    word_t                ch_id_q, ch_id_d, ch_hops_q, ch_hops_d, ch_qv_q, ch_qv_d;
    logic                 ch_valid_q, ch_valid_d, sel_done_q, sel_done_d, adv_drop_q, adv_drop_d;
    logic [IW:0]          ch_count_q, ch_count_d;

    logic [IW:0]   cnt, lim;
    logic          hit, free_found, vic_found, cur_found, take;
    logic [IW-1:0] hit_idx, free_idx, vic_idx;
    word_t         vic_qv;

    // Table lookups used by the UPDATE step.
    always_comb begin
        cnt        = '0;
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        vic_found  = 1'b0;
        vic_idx    = '0;
        vic_qv     = '0;
        lim = (HB_CHlimit < WORD_WIDTH'(DEPTH)) ? HB_CHlimit[IW:0] : (IW+1)'(DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (IW+1)'(vld_q[i]);
            if (vld_q[i] && id_q[i] == adv_id_q && !hit) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
            if (!vld_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (vld_q[i] && (!vic_found || qv_q[i] < vic_qv)) begin
                vic_found = 1'b1;
                vic_idx   = IW'(i);
                vic_qv    = qv_q[i];
            end
        end
    end

    // Scan step: strict comparisons keep the lower index on a full tie.
    always_comb begin
        cur_found = (scan_idx_q == '0) ? 1'b0 : best_found_q;
        take = vld_q[scan_idx_q] && (!cur_found || qv_q[scan_idx_q] > best_qv_q ||
               (qv_q[scan_idx_q] == best_qv_q && hops_q[scan_idx_q] < best_hops_q));
    end

    always_comb begin
        state_d      = state_q;
        vld_d        = vld_q;
        id_d         = id_q;
        hops_d       = hops_q;
        qv_d         = qv_q;
        age_d        = age_q;
        adv_id_d     = adv_id_q;
        adv_hops_d   = adv_hops_q;
        adv_qv_d     = adv_qv_q;
        pend_d       = pend_q;
        scan_idx_d   = scan_idx_q;
        best_found_d = cur_found | take;
        best_id_d    = take ? id_q[scan_idx_q]   : best_id_q;
        best_hops_d  = take ? hops_q[scan_idx_q] : best_hops_q;
        best_qv_d    = take ? qv_q[scan_idx_q]   : best_qv_q;
        ch_id_d      = ch_id_q;
        ch_hops_d    = ch_hops_q;
        ch_qv_d      = ch_qv_q;
        ch_valid_d   = ch_valid_q;
        sel_done_d   = 1'b0;
        adv_drop_d   = 1'b0;
        ch_count_d   = cnt;
        case (state_q)
            S_IDLE: begin
                if (en_KCH) begin
                    adv_id_d   = fCH_ID;
                    adv_hops_d = fCH_Hops;
                    adv_qv_d   = fCH_QValue;
                    if (age_tick) pend_d = 1'b1;
                    state_d = S_UPDATE;
                end else if (age_tick || pend_q) begin
                    state_d = S_AGE;
                end
            end
            S_UPDATE: begin
                if (hit) begin
                    hops_d[hit_idx] = adv_hops_q;
                    qv_d[hit_idx]   = adv_qv_q;
                    age_d[hit_idx]  = '0;
                end else if (cnt < lim) begin
                    vld_d[free_idx]  = 1'b1;
                    id_d[free_idx]   = adv_id_q;
                    hops_d[free_idx] = adv_hops_q;
                    qv_d[free_idx]   = adv_qv_q;
                    age_d[free_idx]  = '0;
                end else if (lim != '0 && vic_found && adv_qv_q > vic_qv) begin
                    id_d[vic_idx]   = adv_id_q;
                    hops_d[vic_idx] = adv_hops_q;
                    qv_d[vic_idx]   = adv_qv_q;
                    age_d[vic_idx]  = '0;
                end else begin
                    adv_drop_d = 1'b1;
                end
                scan_idx_d = '0;
                state_d    = S_SCAN;
            end
            S_AGE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (vld_q[i]) begin
                        age_d[i] = (age_q[i] == '1) ? age_q[i] : age_q[i] + 1'b1;
                        if (age_limit != '0 && age_d[i] >= age_limit) vld_d[i] = 1'b0;
                    end
                end
                pend_d     = 1'b0;
                scan_idx_d = '0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                if (scan_idx_q == IW'(DEPTH - 1)) begin
                    ch_valid_d = best_found_d;
                    ch_id_d    = best_found_d ? best_id_d   : '0;
                    ch_hops_d  = best_found_d ? best_hops_d : '1;
                    ch_qv_d    = best_found_d ? best_qv_d   : '0;
                    sel_done_d = 1'b1;
                    state_d    = S_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A tick arriving while busy is remembered (one deep) for the next IDLE.
        if (age_tick && state_q != S_IDLE) pend_d = 1'b1;
        if (HB_reset) begin
            state_d    = S_IDLE;
            vld_d      = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
            pend_d     = 1'b0;
            ch_id_d    = '0;
            ch_hops_d  = '1;
            ch_qv_d    = '0;
            ch_valid_d = 1'b0;
            sel_done_d = 1'b0;
            adv_drop_d = 1'b0;
            ch_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vld_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                hops_q[i] <= '0;
                qv_q[i]   <= '0;
                age_q[i]  <= '0;
            end
            adv_id_q     <= '0;
            adv_hops_q   <= '0;
            adv_qv_q     <= '0;
            pend_q       <= 1'b0;
            scan_idx_q   <= '0;
            best_found_q <= 1'b0;
            best_id_q    <= '0;
            best_hops_q  <= '0;
            best_qv_q    <= '0;
            ch_id_q      <= '0;
            ch_hops_q    <= '1;
            ch_qv_q      <= '0;
            ch_valid_q   <= 1'b0;
            sel_done_q   <= 1'b0;
            adv_drop_q   <= 1'b0;
            ch_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
            hops_q       <= hops_d;
            qv_q         <= qv_d;
            age_q        <= age_d;
            adv_id_q     <= adv_id_d;
            adv_hops_q   <= adv_hops_d;
            adv_qv_q     <= adv_qv_d;
            pend_q       <= pend_d;
            scan_idx_q   <= scan_idx_d;
            best_found_q <= best_found_d;
            best_id_q    <= best_id_d;
            best_hops_q  <= best_hops_d;
            best_qv_q    <= best_qv_d;
            ch_id_q      <= ch_id_d;
            ch_hops_q    <= ch_hops_d;
            ch_qv_q      <= ch_qv_d;
            ch_valid_q   <= ch_valid_d;
            sel_done_q   <= sel_done_d;
            adv_drop_q   <= adv_drop_d;
            ch_count_q   <= ch_count_d;
        end
    end

    assign kch_ready   = (state_q == S_IDLE);
    assign chosenCH    = ch_id_q;
    assign hopsfromCH  = ch_hops_q;
    assign chosenQ     = ch_qv_q;
    assign ch_valid    = ch_valid_q;
    assign ch_count    = ch_count_q;
    assign sel_done    = sel_done_q;
    assign adv_drop    = adv_drop_q;
    assign dbg_state_o = state_q;
endmodule
